// File: rtl/result_reader_pkg.sv
// Shared definitions for the result_reader bus master: FSM state encoding,
// SRAM select bit and the BCD result word type.
package result_reader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_REQ  = 3'd1,
        ST_ADDR = 3'd2,
        ST_READ = 3'd3,
        ST_CAPT = 3'd4,
        ST_OUT  = 3'd5,
        ST_FIN  = 3'd6
    } state_t;

    // Address bit 0 low selects SRAM; high would select the EPROM.
    localparam logic SRAM_SEL = 1'b0;

    localparam int IDX_W  = 21;
    localparam int ADDR_W = IDX_W + 1;

    typedef logic [15:0] result_word_t;

endpackage

// File: rtl/result_reader_bcd_nibble_check.sv
// Combinational BCD validity check: flags a 16-bit word holding any nibble above 9.
module bcd_nibble_check
    import result_reader_pkg::*;
(
    input  result_word_t word_i,
    output logic         invalid_o
);

    logic [3:0] nib_bad;

    for (genvar gi = 0; gi < 4; gi++) begin : g_nib
        assign nib_bad[gi] = (word_i[gi*4 +: 4] > 4'd9);
    end

    assign invalid_o = |nib_bad;

endmodule

// File: rtl/result_reader.sv
// Reads BCD result words from SRAM over the shared bus and streams them out on a
// valid/ready port. Optional BCD checker enabled by RESULT_READER_BCD_CHECK_EN.
module result_reader
    import result_reader_pkg::*;
#(
    parameter int RD_LAT = 1,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [IDX_W-1:0]  base_idx,
    input  logic [CNT_W-1:0]  count,
    output logic              bus_req,
    input  logic              bus_gnt,
    output logic [ADDR_W-1:0] addr_bus,
    input  logic [15:0]       data_bus,
    output logic              rd,
    output logic [15:0]       out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
`ifdef RESULT_READER_BCD_CHECK_EN
    output logic              done,
    output logic              bcd_err
`else
    output logic              done
`endif
);

    localparam logic [1:0]       LAT_LAST = 2'(RD_LAT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [CNT_W-1:0]  rem_q, rem_d;
    logic [1:0]        lat_q, lat_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    result_word_t      out_data_q, out_data_d;
    logic              bus_req_q, bus_req_d;
    logic              rd_q, rd_d;
    logic              out_valid_q, out_valid_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        rem_d       = rem_q;
        lat_d       = lat_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        busy_d      = busy_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    idx_d   = base_idx;
                    rem_d   = count;
                    busy_d  = 1'b1;
                    state_d = (count == '0) ? ST_FIN : ST_REQ;
                end
            end
            ST_REQ: begin
                if (bus_gnt) begin
                    state_d = ST_ADDR;
                end
            end
            ST_ADDR: begin
                lat_d   = '0;
                state_d = bus_gnt ? ST_READ : ST_REQ;
            end
            ST_READ: begin
                if (!bus_gnt) begin
                    state_d = ST_REQ;
                end else if (lat_q == LAT_LAST) begin
                    state_d = ST_CAPT;
                end else begin
                    lat_d = lat_q + 2'd1;
                end
            end
            ST_CAPT: begin
                // A grant lost right at capture still abandons the word; idx is untouched.
                if (!bus_gnt) begin
                    state_d = ST_REQ;
                end else begin
                    out_data_d  = data_bus;
                    out_valid_d = 1'b1;
                    state_d     = ST_OUT;
                end
            end
            ST_OUT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    idx_d       = idx_q + 1'b1;
                    rem_d       = rem_q - CNT_ONE;
                    state_d     = (rem_q == CNT_ONE) ? ST_FIN : ST_ADDR;
                end
            end
            ST_FIN: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Outputs are decoded from the next state so they leave the block registered.
        bus_req_d = state_d inside {ST_REQ, ST_ADDR, ST_READ, ST_CAPT, ST_OUT};
        rd_d      = (state_d == ST_READ);
        done_d    = (state_d == ST_FIN);
        addr_d    = (state_d == ST_ADDR) ? {idx_d, SRAM_SEL} : addr_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            rem_q       <= '0;
            lat_q       <= '0;
            addr_q      <= '0;
            out_data_q  <= '0;
            bus_req_q   <= 1'b0;
            rd_q        <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            rem_q       <= rem_d;
            lat_q       <= lat_d;
            addr_q      <= addr_d;
            out_data_q  <= out_data_d;
            bus_req_q   <= bus_req_d;
            rd_q        <= rd_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign bus_req   = bus_req_q;
    assign addr_bus  = addr_q;
    assign rd        = rd_q;
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign done      = done_q;

`ifdef RESULT_READER_BCD_CHECK_EN
    logic bcd_err_q, bcd_err_d;
    logic word_bad;

    bcd_nibble_check u_bcd_check (
        .word_i    (data_bus),
        .invalid_o (word_bad)
    );

    always_comb begin
        bcd_err_d = bcd_err_q;
        if (state_q == ST_IDLE && start) begin
            bcd_err_d = 1'b0;
        end else if (state_q == ST_CAPT && bus_gnt && word_bad) begin
            bcd_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bcd_err_q <= 1'b0;
        end else begin
            bcd_err_q <= bcd_err_d;
        end
    end

    assign bcd_err = bcd_err_q;
`endif

endmodule

// File: tb/tb_result_reader.sv
// Scoreboard bench for result_reader: directed bus scenarios plus randomized
// transfers against a queue-based model of the SRAM word stream.
module tb_result_reader;

    localparam int RD_LAT = 2;
    localparam int CNT_W  = 8;
    localparam int K      = RD_LAT + 3;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic [20:0]       base_idx = '0;
    logic [CNT_W-1:0]  count = '0;
    logic              bus_req;
    logic              bus_gnt = 1'b0;
    logic [21:0]       addr_bus;
    logic [15:0]       data_bus;
    logic              rd;
    logic [15:0]       out_data;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic              busy;
    logic              done;
`ifdef RESULT_READER_BCD_CHECK_EN
    logic              bcd_err;
`endif

    result_reader #(.RD_LAT(RD_LAT), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .base_idx  (base_idx),
        .count     (count),
        .bus_req   (bus_req),
        .bus_gnt   (bus_gnt),
        .addr_bus  (addr_bus),
        .data_bus  (data_bus),
        .rd        (rd),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .done      (done)
`ifdef RESULT_READER_BCD_CHECK_EN
        ,.bcd_err  (bcd_err)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // SRAM model: data appears RD_LAT cycles after rd is seen high, garbage otherwise.
    logic [15:0] sram [int];
    logic        vpipe [RD_LAT];
    logic [15:0] dpipe [RD_LAT];

    always @(posedge clk) begin
        for (int i = RD_LAT - 1; i > 0; i--) begin
            vpipe[i] <= vpipe[i-1];
            dpipe[i] <= dpipe[i-1];
        end
        vpipe[0] <= rd;
        dpipe[0] <= sram.exists(int'(addr_bus[21:1])) ? sram[int'(addr_bus[21:1])] : 16'hBEEF;
    end

    assign data_bus = vpipe[RD_LAT-1] ? dpipe[RD_LAT-1] : 16'hDEAD;

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Scoreboard queues filled by the stimulus side.
    logic [21:0] exp_addr [$];
    logic [15:0] exp_data [$];

    int   rd_rises  = 0;
    int   done_cnt  = 0;
    int   done_cyc  = 0;
    int   done_long = 0;
    bit   req_seen  = 0;

    initial begin
        bit          rd_prev = 0;
        bit          hold_prev = 0;
        bit          done_prev = 0;
        logic [15:0] held = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                rd_prev = 0; hold_prev = 0; done_prev = 0;
                continue;
            end
            if (rd && !rd_prev) begin
                rd_rises++;
                if (exp_addr.size() == 0) check("rd_unexpected", 1, 0);
                else check("rd_addr", addr_bus, exp_addr[0]);
            end
            rd_prev = rd;
            if (out_valid && rd) check("rd_during_out", 1, 0);
            if (out_valid && hold_prev) check("out_stable", out_data, held);
            if (out_valid && out_ready) begin
                if (exp_data.size() == 0) begin
                    check("out_unexpected", 1, 0);
                end else begin
                    check("out_data", out_data, exp_data.pop_front());
                    void'(exp_addr.pop_front());
                end
            end
            hold_prev = out_valid && !out_ready;
            held      = out_data;
            if (bus_req) req_seen = 1;
            if (done) begin
                if (done_prev) done_long++;
                done_cnt++;
                done_cyc = cyc;
            end
            done_prev = done;
        end
    end

    bit gnt_rand = 0;
    bit rdy_rand = 0;
    int t0 = 0;
    bit exp_bcd = 0;

    task automatic tick();
        @(posedge clk);
        #2;
        if (gnt_rand) bus_gnt = ($urandom_range(0, 3) != 0);
        if (rdy_rand) out_ready = ($urandom_range(0, 2) != 0);
    endtask

    function automatic logic [15:0] bcd_word(input int v);
        logic [15:0] w = '0;
        int d = v;
        for (int k = 0; k < 4; k++) begin
            w = w | 16'((d % 10) << (4 * k));
            d = d / 10;
        end
        return w;
    endfunction

    function automatic bit bcd_bad(input logic [15:0] w);
        for (int k = 0; k < 4; k++)
            if (((w >> (4 * k)) & 16'hF) > 16'd9) return 1;
        return 0;
    endfunction

    task automatic start_xfer(input logic [20:0] base, input int n);
        logic [20:0] idx;
        exp_bcd = 0;
        for (int i = 0; i < n; i++) begin
            idx = base + 21'(i);
            exp_addr.push_back({idx, 1'b0});
            exp_data.push_back(sram[int'(idx)]);
            if (bcd_bad(sram[int'(idx)])) exp_bcd = 1;
        end
        req_seen = 0;
        rd_rises = 0;
        base_idx = base;
        count    = CNT_W'(n);
        start    = 1'b1;
        t0       = cyc;
        tick();
        start    = 1'b0;
        base_idx = 21'($urandom);
        count    = CNT_W'($urandom);
    endtask

    task automatic wait_done(input int n, input bit check_lat);
        int d0 = done_cnt;
        for (int i = 0; i < 3000 && done_cnt == d0; i++) tick();
        check("done_seen", 32'(done_cnt != d0), 1);
        if (check_lat) check("done_latency", done_cyc - t0, 2 + n * K);
        tick();
        check("busy_after_done", busy, 0);
        check("scoreboard_drained", exp_data.size(), 0);
`ifdef RESULT_READER_BCD_CHECK_EN
        check("bcd_err", bcd_err, exp_bcd);
`endif
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_bus_req"},   bus_req,   0);
        check({tag, "_addr"},      addr_bus,  0);
        check({tag, "_rd"},        rd,        0);
        check({tag, "_out_data"},  out_data,  0);
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_busy"},      busy,      0);
        check({tag, "_done"},      done,      0);
`ifdef RESULT_READER_BCD_CHECK_EN
        check({tag, "_bcd_err"},   bcd_err,   0);
`endif
    endtask

    initial begin
        logic [20:0] base;
        int          n;

        for (int i = 0; i < RD_LAT; i++) begin
            vpipe[i] = 0;
            dpipe[i] = '0;
        end
        repeat (3) tick();
        check_reset_vals("reset");
        rst = 1'b0;
        tick();

        // Basic 3-word transfer with a start pulse while busy that must be ignored.
        sram[5] = 16'h0012; sram[6] = 16'h0345; sram[7] = 16'h9999;
        bus_gnt = 1'b1; out_ready = 1'b1;
        start_xfer(21'd5, 3);
        check("busy_after_start", busy, 1);
        tick();
        base_idx = 21'd999; count = 8'd5; start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(3, 1);
        $display("xfer base=5 count=3 done_latency=%0d", done_cyc - t0);

        // Zero-length transfer never touches the bus.
        start_xfer(21'd50, 0);
        wait_done(0, 0);
        check("count0_no_req", req_seen, 0);
        check("count0_no_rd", rd_rises, 0);
        $display("xfer count=0 req_seen=%0d", req_seen);

        // Index wrap at the top of the SRAM index space.
        sram[21'h1FFFFF] = 16'h0777; sram[0] = 16'h0100;
        start_xfer(21'h1FFFFF, 2);
        wait_done(2, 1);
        $display("xfer wrap base=1fffff count=2");

        // Grant lost for 4 cycles during READ of the first word.
        sram[100] = 16'h1111; sram[101] = 16'h2222; sram[102] = 16'h3333;
        start_xfer(21'd100, 3);
        for (int i = 0; i < 200 && !rd; i++) tick();
        check("rd_seen", rd, 1);
        bus_gnt = 1'b0;
        repeat (4) begin
            tick();
            check("rd_low_on_gnt_loss", rd, 0);
        end
        bus_gnt = 1'b1;
        wait_done(3, 0);
        check("reread_count", rd_rises, 4);
        $display("xfer grant drop rd_rises=%0d", rd_rises);

        // Downstream stall of 10 cycles in OUT.
        sram[300] = 16'h4567; sram[301] = 16'h8901;
        out_ready = 1'b0;
        start_xfer(21'd300, 2);
        for (int i = 0; i < 200 && !out_valid; i++) tick();
        check("stall_valid_seen", out_valid, 1);
        repeat (10) begin
            tick();
            check("stall_valid", out_valid, 1);
            check("stall_data", out_data, 16'h4567);
            check("stall_no_rd", rd, 0);
        end
        out_ready = 1'b1;
        wait_done(2, 0);
        $display("xfer ready stall 10 cycles");

        // Non-BCD word is delivered unchanged (and flagged when the checker is built).
        sram[200] = 16'h12A4; sram[201] = 16'h0042;
        start_xfer(21'd200, 2);
        wait_done(2, 1);
        $display("xfer non-bcd word 12a4");

        // Reset in the middle of READ, then a clean restart.
        sram[400] = 16'h0001; sram[401] = 16'h0002; sram[402] = 16'h0003;
        start_xfer(21'd400, 3);
`ifdef RESULT_READER_BCD_CHECK_EN
        check("bcd_err_cleared_by_start", bcd_err, 0);
`endif
        for (int i = 0; i < 200 && !rd; i++) tick();
        check("rd_seen_before_reset", rd, 1);
        rst = 1'b1;
        tick();
        check_reset_vals("midreset");
        rst = 1'b0;
        exp_addr.delete();
        exp_data.delete();
        tick();
        sram[410] = 16'h5555; sram[411] = 16'h6666;
        start_xfer(21'd410, 2);
        wait_done(2, 1);
        $display("xfer after mid-read reset");

        // Randomized transfers with random grant and ready behaviour.
        for (int t = 0; t < 10; t++) begin
            base = (t % 3 == 0) ? 21'h1FFFFF - 21'($urandom_range(0, 3)) : 21'($urandom);
            n    = $urandom_range(1, 6);
            for (int i = 0; i < n; i++)
                sram[int'(base + 21'(i))] = $urandom_range(0, 1) ? 16'($urandom) : bcd_word($urandom_range(0, 9999));
            gnt_rand = (t % 2 == 1);
            rdy_rand = 1;
            bus_gnt  = 1'b1;
            start_xfer(base, n);
            tick();
            base_idx = 21'($urandom); count = CNT_W'($urandom_range(1, 9)); start = 1'b1;
            tick();
            start = 1'b0;
            wait_done(n, 0);
            $display("xfer rand base=%0h count=%0d gnt_rand=%0d", base, n, gnt_rand);
        end

        check("done_one_cycle", done_long, 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
